// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, response codes,
// FSM state type and the lane-index width helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int lane_bits(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, memory-bus and response signals of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; mem_req is held
// until mem_ack (same cycle allowed) or timeout; resp_valid is a one-cycle pulse with no backpressure.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;

  modport slave (
    input  req_valid, req_store, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_store, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for a request,
// and lane selection plus sign/zero extension of returned load data.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int LB   = lane_bits(XLEN),
  localparam int NB   = XLEN / 8
) (
  input  logic [2:0]      op,
  input  logic [LB-1:0]   lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);
  logic [NB-1:0]   be_base;
  logic [XLEN-1:0] shifted;

  always_comb begin
    be_base = '0;
    for (int i = 0; i < NB; i++) be_base[i] = (i < (1 << op[1:0]));
    be      = be_base << lane;
    shifted = rdata >> {lane, 3'b000};

    case (op[1:0])
      2'b00:   wdata_rep = {NB{wdata[7:0]}};
      2'b01:   wdata_rep = {(NB/2){wdata[15:0]}};
      2'b10:   wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    // Signed casts widen with sign extension; LW at XLEN=32 and LD fall through unchanged.
    case (op)
      F3_B:    rdata_ext = XLEN'($signed(shifted[7:0]));
      F3_H:    rdata_ext = XLEN'($signed(shifted[15:0]));
      F3_W:    rdata_ext = XLEN'($signed(shifted[31:0]));
      F3_BU:   rdata_ext = XLEN'(shifted[7:0]);
      F3_HU:   rdata_ext = XLEN'(shifted[15:0]);
      F3_WU:   rdata_ext = XLEN'(shifted[31:0]);
      default: rdata_ext = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: legality/alignment check, word-wide bus access with
// timeout-bounded ack wait, and a one-cycle extended response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic   clk,
  input  logic   rst,
  lsu_if.slave   bus,
  output state_t dbg_state
);
  localparam int LB = lane_bits(XLEN);
  localparam int NB = XLEN / 8;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t            state;
  logic              req_ready_r, mem_req_r, mem_we_r, resp_valid_r, store_q;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [NB-1:0]     mem_be_r, al_be;
  logic [XLEN-1:0]   mem_wdata_r, resp_rdata_r, al_wdata, al_rdata;
  logic [1:0]        resp_err_r;
  logic [CW-1:0]     wait_cnt;
  logic [2:0]        op_q, al_op;
  logic [LB-1:0]     lane_q, al_lane;
  logic              accept, illegal, misaligned;

  assign accept  = bus.req_valid && req_ready_r;
  // In IDLE the aligner works on the incoming request, afterwards on the registered one.
  assign al_op   = (state == ST_IDLE) ? bus.req_op : op_q;
  assign al_lane = (state == ST_IDLE) ? bus.req_addr[LB-1:0] : lane_q;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_store)
      illegal = bus.req_op[2] || (bus.req_op == F3_D && XLEN == 32);
    else
      illegal = (bus.req_op == 3'b111) ||
                (XLEN == 32 && (bus.req_op == F3_D || bus.req_op == F3_WU));
    case (bus.req_op[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .op        (al_op),
    .lane      (al_lane),
    .wdata     (bus.req_wdata),
    .rdata     (bus.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready_r  <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_be_r     <= '0;
      mem_wdata_r  <= '0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= ERR_OK;
      wait_cnt     <= '0;
      op_q         <= '0;
      lane_q       <= '0;
      store_q      <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready_r <= 1'b1;
          if (accept) begin
            op_q        <= bus.req_op;
            lane_q      <= bus.req_addr[LB-1:0];
            store_q     <= bus.req_store;
            req_ready_r <= 1'b0;
            if (illegal || misaligned) begin
              state        <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= '0;
              resp_err_r   <= illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            end else begin
              state       <= ST_ACCESS;
              mem_req_r   <= 1'b1;
              mem_we_r    <= bus.req_store;
              mem_addr_r  <= {bus.req_addr[ADDR_W-1:LB], LB'(0)};
              mem_be_r    <= al_be;
              mem_wdata_r <= al_wdata;
              wait_cnt    <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus.mem_ack) begin
            state        <= ST_RESP;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= ERR_OK;
            resp_rdata_r <= store_q ? '0 : al_rdata;
          end else if (MAX_WAIT > 0 && wait_cnt == CW'(MAX_WAIT - 1)) begin
            state        <= ST_RESP;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= ERR_TIMEOUT;
            resp_rdata_r <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          req_ready_r <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_be     = mem_be_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign dbg_state      = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit and a 64-bit instance share one stimulus port,
// checked against a byte-level behavioural model and hand-computed literals.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, mem_ack = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();
  state_t dbg32, dbg64;

  assign b32.req_valid = req_valid & ~sel64;
  assign b32.req_store = req_store;
  assign b32.req_op    = req_op;
  assign b32.req_addr  = req_addr;
  assign b32.req_wdata = req_wdata[31:0];
  assign b32.mem_ack   = mem_ack & ~sel64;
  assign b32.mem_rdata = mem_rdata[31:0];
  assign b64.req_valid = req_valid & sel64;
  assign b64.req_store = req_store;
  assign b64.req_op    = req_op;
  assign b64.req_addr  = req_addr;
  assign b64.req_wdata = req_wdata;
  assign b64.mem_ack   = mem_ack & sel64;
  assign b64.mem_rdata = mem_rdata;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32), .dbg_state(dbg32));
  load_store_unit #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(4)) dut64 (
    .clk(clk), .rst(rst), .bus(b64), .dbg_state(dbg64));

  logic        o_req, o_we, o_ready, o_resp_valid;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  logic [63:0] o_wdata, o_rdata;
  logic [1:0]  o_err;
  assign o_req        = sel64 ? b64.mem_req : b32.mem_req;
  assign o_we         = sel64 ? b64.mem_we : b32.mem_we;
  assign o_ready      = sel64 ? b64.req_ready : b32.req_ready;
  assign o_resp_valid = sel64 ? b64.resp_valid : b32.resp_valid;
  assign o_addr       = sel64 ? b64.mem_addr : b32.mem_addr;
  assign o_be         = sel64 ? b64.mem_be : {4'b0, b32.mem_be};
  assign o_wdata      = sel64 ? b64.mem_wdata : {32'b0, b32.mem_wdata};
  assign o_rdata      = sel64 ? b64.resp_rdata : {32'b0, b32.resp_rdata};
  assign o_err        = sel64 ? b64.resp_err : b32.resp_err;

  always #5 clk = ~clk;

  // Scoreboard state
  logic [63:0] exp_q[$];
  logic [1:0]  err_q[$];
  logic        exp_access = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [7:0]  exp_be = '0;
  logic [63:0] exp_wdata = '0;
  logic [31:0] cap_addr;
  logic [7:0]  cap_be;
  logic [63:0] cap_wdata, cap_rdata;
  logic        cap_we;
  logic [1:0]  cap_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: byte arithmetic over the access size and lane.
  function automatic logic [1:0] m_err(input logic st, input logic [2:0] op,
                                       input logic [31:0] addr, input int xlen);
    int size;
    bit legal;
    size = 1 << op[1:0];
    if (st) legal = (op < 3) || (op == 3 && xlen == 64);
    else    legal = (op != 7) && !(xlen == 32 && (op == 3 || op == 6));
    if (!legal) return 2'b11;
    if (int'(addr % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] op, input logic [31:0] addr, input int xlen);
    int size, lane;
    size = 1 << op[1:0];
    lane = int'(addr % (xlen / 8));
    return 8'(((1 << size) - 1) << lane);
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] op, input logic [63:0] wd, input int xlen);
    logic [63:0] r;
    int size;
    r = '0;
    size = 1 << op[1:0];
    for (int b = 0; b < xlen / 8; b++) r[b*8 +: 8] = wd[(b % size)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [63:0] rd, input int xlen);
    int size, lane, bits;
    logic [63:0] w, v, mask;
    size = 1 << op[1:0];
    lane = int'(addr % (xlen / 8));
    bits = size * 8;
    w    = (xlen == 32) ? (rd & 64'hFFFF_FFFF) : rd;
    v    = w >> (lane * 8);
    mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v    = v & mask;
    if (!op[2] && v[bits-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // Compare process: bus contents whenever mem_req is up, responses against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_req) begin
        check("bus_req_expected", 64'(exp_access), 64'd1);
        check("bus_addr", 64'(o_addr), 64'(exp_addr));
        check("bus_be", 64'(o_be), 64'(exp_be));
        check("bus_wdata", o_wdata, exp_wdata);
        check("bus_we", 64'(o_we), 64'(exp_we));
      end
      if (o_resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'(o_resp_valid), 64'd0);
        else begin
          check("resp_rdata", o_rdata, exp_q.pop_front());
          check("resp_err", 64'(o_err), 64'(err_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("ready_wait", 64'(o_ready), 64'd1);
  endtask

  // ack_dly: ACCESS cycles before ack (0 = first cycle), negative = never ack.
  task automatic do_req(input logic st, input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] wd, input int ack_dly, input logic [63:0] rd);
    int xlen, n;
    logic [1:0] err;
    xlen       = sel64 ? 64 : 32;
    err        = m_err(st, op, addr, xlen);
    exp_access = (err == 2'b00);
    exp_addr   = addr & ~32'(xlen / 8 - 1);
    exp_be     = m_be(op, addr, xlen);
    exp_wdata  = m_wdata(op, wd, xlen);
    exp_we     = st;
    if (err != 2'b00) begin
      err_q.push_back(err);
      exp_q.push_back(64'd0);
    end else if (ack_dly < 0) begin
      err_q.push_back(2'b10);
      exp_q.push_back(64'd0);
    end else begin
      err_q.push_back(2'b00);
      exp_q.push_back(st ? 64'd0 : m_load(op, addr, rd, xlen));
    end
    wait_ready();
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (err != 2'b00) begin
      check("err_resp_lat", 64'(o_resp_valid), 64'd1);
      check("err_no_req", 64'(o_req), 64'd0);
    end else begin
      check("req_lat", 64'(o_req), 64'd1);
      cap_addr = o_addr; cap_be = o_be; cap_wdata = o_wdata; cap_we = o_we;
      if (ack_dly >= 0) begin
        repeat (ack_dly) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        check("ack_resp_lat", 64'(o_resp_valid), 64'd1);
      end else begin
        n = 0;
        while (o_req && n < 20) begin
          n++;
          @(negedge clk);
        end
        check("timeout_len", 64'(n), 64'd4);
        check("timeout_resp", 64'(o_resp_valid), 64'd1);
        mem_ack = 1'b1; mem_rdata = rd;
      end
      check("req_drop", 64'(o_req), 64'd0);
    end
    cap_err = o_err; cap_rdata = o_rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ready_back", 64'(o_ready), 64'd1);
    check("resp_one_cycle", 64'(o_resp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 64'(o_req), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_addr", 64'(o_addr), 64'd0);
    check("rst_be", 64'(o_be), 64'd0);
    check("rst_wdata", o_wdata, 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_state32", 64'(dbg32), 64'(ST_IDLE));
    check("rst_state64", 64'(dbg64), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);

    // XLEN=32
    do_req(1'b1, 3'b010, 32'h100, 64'hDEAD_BEEF, 0, 64'd0);
    check("sw_be", 64'(cap_be), 64'h0F);
    check("sw_addr", 64'(cap_addr), 64'h100);
    check("sw_err", 64'(cap_err), 64'd0);
    do_req(1'b1, 3'b000, 32'h103, 64'h0000_00A5, 1, 64'd0);
    check("sb_be", 64'(cap_be), 64'h08);
    check("sb_addr", 64'(cap_addr), 64'h100);
    check("sb_wdata", cap_wdata, 64'hA5A5_A5A5);
    check("sb_we", 64'(cap_we), 64'd1);
    do_req(1'b1, 3'b001, 32'h102, 64'h0000_1234, 2, 64'd0);
    check("sh_be", 64'(cap_be), 64'h0C);
    check("sh_wdata", cap_wdata, 64'h1234_1234);
    do_req(1'b0, 3'b000, 32'h102, 64'd0, 0, 64'h1280_FF00);
    check("lb_rdata", cap_rdata, 64'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h102, 64'd0, 1, 64'h1280_FF00);
    check("lbu_rdata", cap_rdata, 64'h0000_0080);
    do_req(1'b0, 3'b101, 32'h102, 64'd0, 0, 64'h1280_FF00);
    check("lhu_rdata", cap_rdata, 64'h0000_1280);
    do_req(1'b0, 3'b001, 32'h100, 64'd0, 0, 64'h0000_8001);
    check("lh_rdata", cap_rdata, 64'hFFFF_8001);
    do_req(1'b0, 3'b010, 32'h104, 64'd0, 3, 64'h8765_4321);
    check("lw_rdata", cap_rdata, 64'h8765_4321);
    do_req(1'b0, 3'b001, 32'h101, 64'd0, 0, 64'd0);
    check("lh_mis_err", 64'(cap_err), 64'h1);
    do_req(1'b0, 3'b111, 32'h100, 64'd0, 0, 64'd0);
    check("ld_op7_err", 64'(cap_err), 64'h3);
    do_req(1'b1, 3'b100, 32'h100, 64'd0, 0, 64'd0);
    do_req(1'b1, 3'b011, 32'h100, 64'd0, 0, 64'd0);
    do_req(1'b0, 3'b110, 32'h100, 64'd0, 0, 64'd0);
    do_req(1'b1, 3'b010, 32'h102, 64'd0, 0, 64'd0);
    check("sw_mis_err", 64'(cap_err), 64'h1);
    do_req(1'b0, 3'b010, 32'h200, 64'd0, -1, 64'hFFFF_FFFF);
    check("timeout_err", 64'(cap_err), 64'h2);
    check("timeout_rdata", cap_rdata, 64'd0);

    // Reset in the middle of an access: no response may follow.
    exp_access = 1'b1; exp_addr = 32'h300; exp_be = 8'h0F; exp_wdata = 64'd0; exp_we = 1'b0;
    wait_ready();
    req_valid = 1'b1; req_store = 1'b0; req_op = 3'b010; req_addr = 32'h300; req_wdata = 64'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_req", 64'(o_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_drop", 64'(o_req), 64'd0);
    check("rst_mid_no_resp", 64'(o_resp_valid), 64'd0);
    check("rst_mid_ready", 64'(o_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", 64'(o_ready), 64'd1);

    // XLEN=64
    sel64 = 1'b1;
    @(negedge clk);
    do_req(1'b0, 3'b011, 32'h108, 64'd0, 0, 64'h8000_0000_0000_00FF);
    check("ld_rdata", cap_rdata, 64'h8000_0000_0000_00FF);
    do_req(1'b1, 3'b011, 32'h110, 64'h0123_4567_89AB_CDEF, 1, 64'd0);
    check("sd_be", 64'(cap_be), 64'hFF);
    check("sd_wdata", cap_wdata, 64'h0123_4567_89AB_CDEF);
    do_req(1'b1, 3'b010, 32'h104, 64'hCAFE_F00D, 0, 64'd0);
    check("sw64_be", 64'(cap_be), 64'hF0);
    check("sw64_addr", 64'(cap_addr), 64'h100);
    check("sw64_wdata", cap_wdata, 64'hCAFE_F00D_CAFE_F00D);
    do_req(1'b0, 3'b110, 32'h104, 64'd0, 0, 64'h8000_0000_1111_1111);
    check("lwu64_rdata", cap_rdata, 64'h0000_0000_8000_0000);
    do_req(1'b0, 3'b010, 32'h104, 64'd0, 2, 64'h8000_0000_1111_1111);
    check("lw64_rdata", cap_rdata, 64'hFFFF_FFFF_8000_0000);
    do_req(1'b0, 3'b000, 32'h107, 64'd0, 0, 64'h8000_0000_0000_0000);
    check("lb64_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 3'b011, 32'h104, 64'd0, 0, 64'd0);
    check("ld_mis_err", 64'(cap_err), 64'h1);
    do_req(1'b0, 3'b111, 32'h100, 64'd0, 0, 64'd0);
    do_req(1'b1, 3'b100, 32'h100, 64'd0, 0, 64'd0);

    repeat (3) @(negedge clk);
    check("pending_resp", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
